// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse character sequencer.
package morse_pkg;

    localparam logic [5:0] CODE_A         = 6'd0;
    localparam logic [5:0] CODE_DIGIT0    = 6'd26;
    localparam logic [5:0] CODE_SPACE     = 6'd36;
    localparam logic [5:0] CODE_MAX_VALID = 6'd36;

    // Symbols reported by the downstream transmitter for the emitted bit stream.
    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_GAP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SEP,
        ST_LGAP,
        ST_WGAP
    } state_t;

endpackage

// File: rtl/morse_rom.sv
// Character code to ITU Morse pattern lookup; pattern is left-aligned, MSB first, 1 = dash.
import morse_pkg::*;

module morse_rom (
    input  logic [5:0] i_code,
    output logic       o_valid,
    output logic [2:0] o_len,
    output logic [4:0] o_pat
);

    always_comb begin
        o_valid = (i_code <= CODE_MAX_VALID);
        o_len   = '0;
        o_pat   = '0;
        case (i_code)
            CODE_A:      {o_len, o_pat} = {3'd2, 5'b01000};
            6'd1:        {o_len, o_pat} = {3'd4, 5'b10000};
            6'd2:        {o_len, o_pat} = {3'd4, 5'b10100};
            6'd3:        {o_len, o_pat} = {3'd3, 5'b10000};
            6'd4:        {o_len, o_pat} = {3'd1, 5'b00000};
            6'd5:        {o_len, o_pat} = {3'd4, 5'b00100};
            6'd6:        {o_len, o_pat} = {3'd3, 5'b11000};
            6'd7:        {o_len, o_pat} = {3'd4, 5'b00000};
            6'd8:        {o_len, o_pat} = {3'd2, 5'b00000};
            6'd9:        {o_len, o_pat} = {3'd4, 5'b01110};
            6'd10:       {o_len, o_pat} = {3'd3, 5'b10100};
            6'd11:       {o_len, o_pat} = {3'd4, 5'b01000};
            6'd12:       {o_len, o_pat} = {3'd2, 5'b11000};
            6'd13:       {o_len, o_pat} = {3'd2, 5'b10000};
            6'd14:       {o_len, o_pat} = {3'd3, 5'b11100};
            6'd15:       {o_len, o_pat} = {3'd4, 5'b01100};
            6'd16:       {o_len, o_pat} = {3'd4, 5'b11010};
            6'd17:       {o_len, o_pat} = {3'd3, 5'b01000};
            6'd18:       {o_len, o_pat} = {3'd3, 5'b00000};
            6'd19:       {o_len, o_pat} = {3'd1, 5'b10000};
            6'd20:       {o_len, o_pat} = {3'd3, 5'b00100};
            6'd21:       {o_len, o_pat} = {3'd4, 5'b00010};
            6'd22:       {o_len, o_pat} = {3'd3, 5'b01100};
            6'd23:       {o_len, o_pat} = {3'd4, 5'b10010};
            6'd24:       {o_len, o_pat} = {3'd4, 5'b10110};
            6'd25:       {o_len, o_pat} = {3'd4, 5'b11000};
            CODE_DIGIT0: {o_len, o_pat} = {3'd5, 5'b11111};
            6'd27:       {o_len, o_pat} = {3'd5, 5'b01111};
            6'd28:       {o_len, o_pat} = {3'd5, 5'b00111};
            6'd29:       {o_len, o_pat} = {3'd5, 5'b00011};
            6'd30:       {o_len, o_pat} = {3'd5, 5'b00001};
            6'd31:       {o_len, o_pat} = {3'd5, 5'b00000};
            6'd32:       {o_len, o_pat} = {3'd5, 5'b10000};
            6'd33:       {o_len, o_pat} = {3'd5, 5'b11000};
            6'd34:       {o_len, o_pat} = {3'd5, 5'b11100};
            6'd35:       {o_len, o_pat} = {3'd5, 5'b11110};
            default:     {o_len, o_pat} = '0;
        endcase
    end

endmodule

// File: rtl/morse_sequencer.sv
// Serialises one character at a time into the dot/dash/gap bit stream decoded by the Morse transmitter.
import morse_pkg::*;

module morse_sequencer #(
    parameter int unsigned DASH_ONES  = 2,
    parameter int unsigned WORD_ZEROS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       char_valid,
    input  logic [5:0] char_in,
    output logic       char_ready,
    output logic       tx_bit,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_len, w_len_nxt;
    logic [4:0] r_pat, w_pat_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_tx_bit;
    logic       r_err, w_err_nxt;

    logic       w_rom_valid;
    logic [2:0] w_rom_len;
    logic [4:0] w_rom_pat;
    logic       w_dash;
    logic       w_mark_last;
    logic       w_wgap_last;
    logic       w_frame_last;
    logic       w_accept;

    morse_rom u_rom (
        .i_code  (char_in),
        .o_valid (w_rom_valid),
        .o_len   (w_rom_len),
        .o_pat   (w_rom_pat)
    );

    assign w_dash       = r_pat[3'd4 - r_idx];
    assign w_mark_last  = !w_dash || (r_cnt == 3'(DASH_ONES - 1));
    assign w_wgap_last  = (r_cnt == 3'(WORD_ZEROS - 1));
    assign w_frame_last = (r_state == ST_LGAP) || ((r_state == ST_WGAP) && w_wgap_last);

    // Ready in the final gap cycle lets the next frame start with no idle bit in between.
    assign char_ready = !reset && ((r_state == ST_IDLE) || w_frame_last);
    assign frame_done = !reset && w_frame_last;
    assign busy       = !reset && (r_state != ST_IDLE);
    assign tx_bit     = r_tx_bit;
    assign err        = r_err;
    assign w_accept   = char_valid && char_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_pat_nxt   = r_pat;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_MARK: begin
                if (w_mark_last) w_state_nxt = ST_SEP;
                else             w_cnt_nxt   = r_cnt + 3'd1;
            end
            ST_SEP: begin
                if ((r_idx + 3'd1) < r_len) begin
                    w_state_nxt = ST_MARK;
                    w_idx_nxt   = r_idx + 3'd1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_LGAP;
                end
            end
            ST_LGAP: w_state_nxt = ST_IDLE;
            ST_WGAP: begin
                if (w_wgap_last) w_state_nxt = ST_IDLE;
                else             w_cnt_nxt   = r_cnt + 3'd1;
            end
            default: ;
        endcase
        if (w_accept) begin
            w_idx_nxt = '0;
            w_cnt_nxt = '0;
            if (char_in == CODE_SPACE) begin
                w_state_nxt = ST_WGAP;
            end else if (w_rom_valid) begin
                w_state_nxt = ST_MARK;
                w_len_nxt   = w_rom_len;
                w_pat_nxt   = w_rom_pat;
            end else begin
                w_state_nxt = ST_IDLE;
                w_err_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_pat    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_tx_bit <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_pat    <= w_pat_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tx_bit <= (w_state_nxt == ST_MARK);
            r_err    <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed scoreboard bench for morse_sequencer at DASH_ONES=2 and DASH_ONES=3.
module tb_morse_sequencer;

    typedef struct packed {
        logic tx;
        logic last;
        logic err;
        logic busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       char_valid = 1'b0;
    logic [5:0] char_in = '0;
    logic       sel = 1'b0;

    logic rdy2, tx2, busy2, done2, err2;
    logic rdy3, tx3, busy3, done3, err3;
    logic o_rdy, o_tx, o_busy, o_done, o_err;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [5:0] codes_q[$];

    string tbl [0:35] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
    };

    always #5 clk = ~clk;

    morse_sequencer #(.DASH_ONES(2), .WORD_ZEROS(3)) dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_in(char_in),
        .char_ready(rdy2), .tx_bit(tx2), .busy(busy2), .frame_done(done2), .err(err2)
    );

    morse_sequencer #(.DASH_ONES(3), .WORD_ZEROS(3)) dut3 (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_in(char_in),
        .char_ready(rdy3), .tx_bit(tx3), .busy(busy3), .frame_done(done3), .err(err3)
    );

    assign o_rdy  = sel ? rdy3  : rdy2;
    assign o_tx   = sel ? tx3   : tx2;
    assign o_busy = sel ? busy3 : busy2;
    assign o_done = sel ? done3 : done2;
    assign o_err  = sel ? err3  : err2;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_bit(input logic tx, input logic last);
        exp_t e;
        e.tx = tx; e.last = last; e.err = 1'b0; e.busy = 1'b1;
        sb.push_back(e);
    endtask

    // Reference bit stream for one accepted code.
    task automatic push_code(input logic [5:0] code);
        int unsigned dash;
        exp_t e;
        dash = sel ? 3 : 2;
        if (code == 6'd36) begin
            for (int i = 0; i < 3; i++) push_bit(1'b0, i == 2);
        end else if (code > 6'd36) begin
            e.tx = 1'b0; e.last = 1'b0; e.err = 1'b1; e.busy = 1'b0;
            sb.push_back(e);
        end else begin
            for (int i = 0; i < tbl[code].len(); i++) begin
                byte c;
                c = tbl[code][i];
                if (c == "-") for (int j = 0; j < int'(dash); j++) push_bit(1'b1, 1'b0);
                else push_bit(1'b1, 1'b0);
                push_bit(1'b0, 1'b0);
            end
            push_bit(1'b0, 1'b1);
        end
    endtask

    // Called at a negedge; drives codes_q through the handshake and checks outputs each cycle.
    task automatic run(input int ncyc, input bit drain);
        int limit;
        exp_t e;
        limit = drain ? 200 : ncyc;
        char_valid = (codes_q.size() > 0);
        if (codes_q.size() > 0) char_in = codes_q[0];
        for (int cyc = 0; cyc < limit; cyc++) begin
            if (drain && sb.size() == 0 && codes_q.size() == 0) break;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("tx_bit", o_tx, e.tx);
                check("frame_done", o_done, e.last);
                check("char_ready", o_rdy, e.busy ? e.last : 1'b1);
                check("busy", o_busy, e.busy);
                check("err", o_err, e.err);
            end else begin
                check("idle_tx_bit", o_tx, 1'b0);
                check("idle_busy", o_busy, 1'b0);
                check("idle_ready", o_rdy, 1'b1);
                check("idle_err", o_err, 1'b0);
            end
            if (char_valid && o_rdy) push_code(codes_q.pop_front());
            @(posedge clk); #1;
            char_valid = (codes_q.size() > 0);
            if (codes_q.size() > 0) char_in = codes_q[0];
            @(negedge clk);
        end
        if (drain) begin
            n_assert++;
            assert (sb.size() == 0 && codes_q.size() == 0) else begin
                n_fail++;
                $error("FAIL timeout: observed %0d pending expected 0", sb.size() + codes_q.size());
            end
        end
    endtask

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_tx"}, o_tx, 1'b0);
        check({tag, "_ready"}, o_rdy, 1'b0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_done"}, o_done, 1'b0);
        check({tag, "_err"}, o_err, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        char_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); @(negedge clk);
            reset_outputs_zero("reset");
        end
        reset = 1'b0;
        sb.delete();
        @(posedge clk); @(negedge clk);
        check("ready_after_reset", o_rdy, 1'b1);
        check("busy_after_reset", o_busy, 1'b0);
    endtask

    initial begin
        do_reset(3);

        codes_q = '{6'd4};                      // E: 1,0,0
        run(0, 1'b1);
        codes_q = '{6'd0, 6'd19};               // A then T back-to-back
        run(0, 1'b1);
        codes_q = '{6'd4, 6'd36, 6'd19};        // E, word space, T
        run(0, 1'b1);
        codes_q = '{6'd50, 6'd4};               // invalid then E
        run(0, 1'b1);
        codes_q = '{6'd35, 6'd26, 6'd16};       // boundary digits and a mixed letter
        run(0, 1'b1);

        // Reset during the 4th bit of "0"
        codes_q = '{6'd26};
        run(4, 1'b0);
        reset = 1'b1;
        #1;
        check("midreset_ready_comb", o_rdy, 1'b0);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            reset_outputs_zero("midreset");
        end
        reset = 1'b0;
        sb.delete();
        @(posedge clk); @(negedge clk);
        check("midreset_ready_release", o_rdy, 1'b1);
        codes_q = '{6'd4};
        run(0, 1'b1);

        // DASH_ONES = 3 instance
        sel = 1'b1;
        do_reset(2);
        codes_q = '{6'd19, 6'd0, 6'd36};
        run(0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Character-level controller that drives the Morse transmitter's serial `in_tx` input. It accepts one character code at a time over a valid/ready handshake and looks up its dot/dash pattern. It then emits the exact bit stream the transmitter FSM decodes: dot = `10`, dash = `1…10`, letter gap = one extra `0`. The result is that the transmitter reports `01` for each dot, `10` for each dash and `11` at each gap. The block sits between the character source and the transmitter, one bit per clock.

## Interface
- `DASH_ONES`, default 2: number of `1` bits per dash; legal range 2..7.
- `WORD_ZEROS`, default 3: number of `0` bits emitted for a word-space code; legal range 1..7.
- `clk`  in  1  system clock; one serial bit per cycle.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `char_valid`  in  1  a character code is offered on `char_in`.
- `char_in`  in  6  character code: 0–25 = A–Z, 26–35 = digits 0–9, 36 = word space, 37–63 = invalid.
- `char_ready`  out  1  the sequencer can accept a code this cycle.
- `tx_bit`  out  1  serial bit to the transmitter `in_tx`; registered.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse on the last bit cycle of a frame.
- `err`  out  1  one-cycle pulse one cycle after an invalid code is accepted.

## Operation
- **FSM states:**
  - IDLE: drives `tx_bit` = 0.
  - MARK: emits the `1` bits of the current element.
  - SEP: emits one `0` after each element.
  - LGAP: emits one `0` after the last element's SEP.
  - WGAP: emits `WORD_ZEROS` zeros.
- **Accept:** occurs when `char_valid && char_ready`. `char_ready` = 1 in IDLE and in the final cycle of LGAP or WGAP; it is 0 otherwise.
- **Latching on accept:** the block latches `len` (1..5 elements) and `pat` (5 bits, MSB-first, 1 = dash) from the ROM. It resets the element index to 0 and the `1`-bit counter to 0.
- **Transitions:**
  - Accept with a letter or digit → MARK.
  - MARK → SEP after 1 cycle for a dot, or `DASH_ONES` cycles for a dash.
  - SEP → MARK if more elements remain; otherwise SEP → LGAP.
  - LGAP → IDLE, or → MARK/WGAP on a back-to-back accept.
  - Accept with code 36 → WGAP, count `WORD_ZEROS`, then → IDLE or the next frame.
  - Accept with an invalid code → stay in IDLE, pulse `err`, emit no bits.
- **Frame length** = Σ(dot: 2, dash: `DASH_ONES`+1) + 1.
  - "A" (`.-`) = 6 bits.
  - "0" (`-----`) = 5·(`DASH_ONES`+1)+1 = 16 bits at the default.
- **Busy:** `busy` = 1 in MARK, SEP, LGAP and WGAP.
- **Invalid codes:** never alter `tx_bit`.
- **Patterns:** standard ITU Morse for A–Z and 0–9.

## Timing
- **Reset:** while `reset` is high all outputs are 0, including `char_ready`. `char_ready` = 1 in the first cycle after release. The state is IDLE.
- **Latency:** a code accepted at edge k drives its first `tx_bit` in cycle k+1. There are no pipeline bubbles.
- **Back-to-back frames:** with `char_valid` held high, frames are contiguous: the last LGAP/WGAP zero is followed directly by the next frame's first bit.
- **`frame_done`:** coincides with the final LGAP or WGAP cycle. It is not pulsed for invalid codes.
- **`err`:** asserts in cycle k+1 for an invalid code accepted at edge k.
- **Reset mid-frame:** aborts immediately. `tx_bit` = 0 from the next edge and the latched pattern is discarded. The transmitter shares the same reset.
- **Unaccepted codes:** `char_in` is ignored when `char_ready` = 0. The source must hold `char_valid` and `char_in` stable until they are accepted.

## Structure
- **Package `morse_pkg`:**
  - code constants `CODE_A`=0, `CODE_DIGIT0`=26, `CODE_SPACE`=36, `CODE_MAX_VALID`=36;
  - transmitter symbol constants `SYM_NONE`=2'b00, `SYM_DOT`=2'b01, `SYM_DASH`=2'b10, `SYM_GAP`=2'b11;
  - the state enum.
- **Sub-module `morse_rom`:** combinational lookup from `char_in` (6 bits) to {`valid`, `len`[2:0], `pat`[4:0]}, instantiated once.

## Test plan
- **Reset then "E":** reset for 3 cycles, then present "E" (code 4) → `tx_bit` = 1,0,0. The transmitter outputs 01 then 11. `frame_done` is pulsed on the 3rd bit.
- **"A" then "T" back-to-back:** present "A" (0) and "T" (19) with `char_valid` held → `tx_bit` = 1,0,1,1,0,0,1,1,0,0 with no gap cycles. `char_ready` is high only on the 6th and 10th bit cycles.
- **Word space at `WORD_ZEROS`=3:** present code 36 → `tx_bit` = 0,0,0 and `busy` = 1 for 3 cycles. The transmitter reports 11 each cycle.
- **Invalid code:** present code 50 → `err` pulses 1 cycle later, `tx_bit` stays 0, `busy` = 0 and `char_ready` returns high next cycle.
- **Reset mid-frame:** assert `reset` during the 4th bit of "0" (code 26) → `tx_bit` = 0 and `char_ready` = 0 while reset is held. After release the next code, "E", emits 1,0,0 cleanly.
- **Dash length at `DASH_ONES`=3:** present "T" → `tx_bit` = 1,1,1,0,0 and the transmitter reports 10 then 11.
